// File: rtl/rs_latch_sequencer_pkg.sv
// rs_seq_pkg -- shared types for the RS latch write sequencer.
//   seq_state_e : sequencer FSM states
//   SET / CLR   : {S, R} drive codes for storing a 1 / a 0
//   rs_code()   : maps a write value to its {S, R} code
package rs_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

    // Bit 1 is S, bit 0 is R. The two codes never share a high bit, so a
    // selected latch can never see R=S=1.
    localparam logic [1:0] SET = 2'b10;
    localparam logic [1:0] CLR = 2'b01;

    function automatic logic [1:0] rs_code(input logic val);
        return val ? SET : CLR;
    endfunction

endpackage

// File: rtl/rs_latch_sequencer_rr_arb2.sv
// rr_arb2 -- two-way round-robin arbiter.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : grants may be issued this cycle
//   req_i[1:0]   : request vector
//   gnt_o[1:0]   : one-hot grant (zero when en_i is low or nothing requested)
// The pointer moves only when a grant is issued, so the requester that was
// not served last wins the next tie. Reset makes requester 0 win first.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic prio_q;   // 1: requester 1 wins a tie
    logic prio_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (|gnt_o) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/rs_latch_sequencer.sv
// rs_latch_sequencer -- writes single bits into a bank of gated RS latches.
// Each write runs IDLE -> SETUP -> PULSE -> HOLD -> IDLE: R/S are set up
// with E low, E is pulsed for PULSE_CYCLES, then E drops while R/S are
// still held, and done pulses.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   reqN_valid/ready          : two write requesters, accepted when both high
//   reqN_idx, reqN_val        : target latch and value (1 = set, 0 = reset)
//   lat_R, lat_S, lat_E       : per-latch drives
//   lat_Q                     : latch outputs fed back for readback
//   busy, done, err           : not idle / write finished / readback mismatch
//
// Build option RS_SEQ_READBACK_CHECK_EN: when defined, the selected latch is
// compared with the written value during HOLD and a mismatch (or an index
// outside the bank) sets err until reset. When undefined err is tied low
// and lat_Q is ignored.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | waiting; the arbiter may accept one request
// ST_SETUP | R/S driven on the selected bit, E low
// ST_PULSE | E high on the selected bit, down-counter runs
// ST_HOLD  | E low, R/S held, done high, readback sampled
module rs_latch_sequencer
    import rs_seq_pkg::*;
#(
    parameter  int N_LATCH      = 4,
    parameter  int PULSE_CYCLES = 2,
    localparam int IDX_W        = $clog2(N_LATCH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [IDX_W-1:0]   req0_idx,
    input  logic               req0_val,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [IDX_W-1:0]   req1_idx,
    input  logic               req1_val,
    output logic [N_LATCH-1:0] lat_R,
    output logic [N_LATCH-1:0] lat_S,
    output logic [N_LATCH-1:0] lat_E,
    input  logic [N_LATCH-1:0] lat_Q,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CNT_W = 4;

    seq_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_LATCH-1:0] lat_r_q;
    logic [N_LATCH-1:0] lat_s_q;
    logic [N_LATCH-1:0] lat_e_q;
    logic               done_q;

    logic [1:0]         gnt;
    logic               arb_en;
    logic               acc;
    logic [IDX_W-1:0]   acc_idx;
    logic               acc_val;
    logic [1:0]         acc_code;
    logic [N_LATCH-1:0] acc_sel;

    // An index outside the bank decodes to no bit at all, so the write
    // sequences normally with nothing driven.
    function automatic logic [N_LATCH-1:0] decode_idx(input logic [IDX_W-1:0] idx);
        logic [N_LATCH-1:0] dec;
        dec = '0;
        for (int i = 0; i < N_LATCH; i++) begin
            if (idx == IDX_W'(i)) begin
                dec[i] = 1'b1;
            end
        end
        return dec;
    endfunction

    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (arb_en),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign acc        = |gnt;
    assign acc_idx    = gnt[1] ? req1_idx : req0_idx;
    assign acc_val    = gnt[1] ? req1_val : req0_val;
    assign acc_code   = rs_code(acc_val);
    assign acc_sel    = decode_idx(acc_idx);

`ifdef RS_SEQ_READBACK_CHECK_EN
    logic               val_q;
    logic               err_q;
    logic [N_LATCH-1:0] rb_sel;
    logic               rb_bad;

    // R/S are still held in HOLD, so they double as the captured selection.
    assign rb_sel = lat_r_q | lat_s_q;
    assign rb_bad = !(|rb_sel) || ((|(lat_Q & rb_sel)) != val_q);
    assign err    = err_q;
`else
    logic unused_lat_q;
    assign unused_lat_q = ^lat_Q;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lat_r_q <= '0;
            lat_s_q <= '0;
            lat_e_q <= '0;
            done_q  <= 1'b0;
`ifdef RS_SEQ_READBACK_CHECK_EN
            val_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        state_q <= ST_SETUP;
                        lat_s_q <= acc_sel & {N_LATCH{acc_code[1]}};
                        lat_r_q <= acc_sel & {N_LATCH{acc_code[0]}};
                        lat_e_q <= '0;
`ifdef RS_SEQ_READBACK_CHECK_EN
                        val_q   <= acc_val;
`endif
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_PULSE;
                    lat_e_q <= lat_r_q | lat_s_q;
                    cnt_q   <= CNT_W'(PULSE_CYCLES - 1);
                end
                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_HOLD;
                        lat_e_q <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    state_q <= ST_IDLE;
                    lat_r_q <= '0;
                    lat_s_q <= '0;
`ifdef RS_SEQ_READBACK_CHECK_EN
                    if (rb_bad) begin
                        err_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                    lat_r_q <= '0;
                    lat_s_q <= '0;
                    lat_e_q <= '0;
                end
            endcase
        end
    end

    assign lat_R = lat_r_q;
    assign lat_S = lat_s_q;
    assign lat_E = lat_e_q;
    assign done  = done_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
